instr_encoder_loader: RTL

- Inverse of the main instruction decoder path: accepts decoded instruction descriptions (class, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready stream.
- Encodes each one into a 32-bit RV32I word and writes it sequentially into instruction memory from a programmed base address.
- Used by the testbench program loader and the self-test boot path to build programs without an external assembler.

---
 rtl/encoder_pkg.sv | 74 +++++++
 rtl/instr_word_encoder.sv | 82 ++++++++
 rtl/instr_encoder_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder/loader.
// Holds class/error enums, the NOP word, opcode constants and field positions.
package encoder_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [3:0] {
    CLS_LUI    = 4'd0,
    CLS_AUIPC  = 4'd1,
    CLS_JAL    = 4'd2,
    CLS_JALR   = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LOAD   = 4'd5,
    CLS_STORE  = 4'd6,
    CLS_I_ALU  = 4'd7,
    CLS_R_ALU  = 4'd8
  } instr_class_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CLASS = 2'd1,
    ERR_IMM   = 2'd2,
    ERR_ADDR  = 2'd3
  } err_code_e;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

  // Base opcodes shared with the decoder path
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

  typedef struct packed {
    instr_class_e      cls;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [WORD_W-1:0] imm;
  } instr_desc_t;

  // R/I/S/B layout: 7 | 5 | rs1 | f3 | 5 | opcode
  function automatic logic [WORD_W-1:0] pack_risb(input logic [6:0] hi7,
                                                  input logic [4:0] mid5,
                                                  input logic [4:0] rs1,
                                                  input logic [2:0] f3,
                                                  input logic [4:0] lo5,
                                                  input logic [6:0] opc);
    return (WORD_W'(hi7) << F7_LSB) | (WORD_W'(mid5) << RS2_LSB) |
           (WORD_W'(rs1) << RS1_LSB) | (WORD_W'(f3) << F3_LSB) |
           (WORD_W'(lo5) << RD_LSB) | WORD_W'(opc);
  endfunction

  // U/J layout: 20-bit upper field | rd | opcode
  function automatic logic [WORD_W-1:0] pack_uj(input logic [19:0] up20,
                                                input logic [4:0]  rd,
                                                input logic [6:0]  opc);
    return (WORD_W'(up20) << F3_LSB) | (WORD_W'(rd) << RD_LSB) | WORD_W'(opc);
  endfunction

endpackage

// File: rtl/instr_word_encoder.sv
// Combinational RV32I format packer with immediate range checks.
// Emits NOP_WORD plus an error code for illegal classes or out-of-range immediates.
module instr_word_encoder
  import encoder_pkg::*;
(
  input  instr_desc_t        desc,
  output logic [WORD_W-1:0]  word,
  output err_code_e          err
);

  logic [WORD_W-1:0] imm;
  logic [WORD_W-1:0] raw;
  logic              bad_imm;
  logic              i_ok;
  logic              b_ok;
  logic              j_ok;
  logic              is_shift;

  assign imm      = desc.imm;
  assign i_ok     = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign b_ok     = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign j_ok     = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
  assign is_shift = (desc.f3 == 3'b001) || (desc.f3 == 3'b101);

  always_comb begin
    raw     = NOP_WORD;
    bad_imm = 1'b0;
    err     = ERR_NONE;
    case (desc.cls)
      CLS_LUI: begin
        raw     = pack_uj(imm[31:12], desc.rd, OPC_LUI);
        bad_imm = imm[11:0] != '0;
      end
      CLS_AUIPC: begin
        raw     = pack_uj(imm[31:12], desc.rd, OPC_AUIPC);
        bad_imm = imm[11:0] != '0;
      end
      CLS_JAL: begin
        raw     = pack_uj({imm[20], imm[10:1], imm[11], imm[19:12]}, desc.rd, OPC_JAL);
        bad_imm = !j_ok;
      end
      CLS_JALR: begin
        raw     = pack_risb(imm[11:5], imm[4:0], desc.rs1, desc.f3, desc.rd, OPC_JALR);
        bad_imm = !i_ok;
      end
      CLS_BRANCH: begin
        raw     = pack_risb({imm[12], imm[10:5]}, desc.rs2, desc.rs1, desc.f3,
                            {imm[4:1], imm[11]}, OPC_BRANCH);
        bad_imm = !b_ok;
      end
      CLS_LOAD: begin
        raw     = pack_risb(imm[11:5], imm[4:0], desc.rs1, desc.f3, desc.rd, OPC_LOAD);
        bad_imm = !i_ok;
      end
      CLS_STORE: begin
        raw     = pack_risb(imm[11:5], desc.rs2, desc.rs1, desc.f3, imm[4:0], OPC_STORE);
        bad_imm = !i_ok;
      end
      CLS_I_ALU: begin
        // Shifts carry funct7 in the upper bits and a 5-bit shamt
        if (is_shift) begin
          raw     = pack_risb(desc.f7, imm[4:0], desc.rs1, desc.f3, desc.rd, OPC_OP_IMM);
          bad_imm = imm[31:5] != '0;
        end else begin
          raw     = pack_risb(imm[11:5], imm[4:0], desc.rs1, desc.f3, desc.rd, OPC_OP_IMM);
          bad_imm = !i_ok;
        end
      end
      CLS_R_ALU: begin
        raw = pack_risb(desc.f7, desc.rs2, desc.rs1, desc.f3, desc.rd, OPC_OP);
      end
      default: begin
        err = ERR_CLASS;
      end
    endcase
    if (err == ERR_NONE && bad_imm) begin
      err = ERR_IMM;
    end
    word = (err == ERR_NONE) ? raw : NOP_WORD;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams decoded instruction descriptors into instruction memory as RV32I words.
// Optional running XOR checksum of written words under ENCODER_CHECKSUM_EN.
module instr_encoder_loader
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [3:0]        in_class_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs1_i,
  input  logic [4:0]        in_rs2_i,
  input  logic [2:0]        in_funct3_i,
  input  logic [6:0]        in_funct7_i,
  input  logic [XLEN-1:0]   in_imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic [ADDR_W-1:0] word_count_o
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [XLEN-1:0]   checksum_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  err_code_e         code_q, code_d;
  logic [XLEN-1:0]   csum_q, csum_d;
  logic              busy_q, done_q;
  logic              ready_c;
  logic              handshake;
  logic              at_max;

  instr_desc_t       desc;
  logic [WORD_W-1:0] enc_word;
  err_code_e         enc_err;

  assign desc = '{cls: instr_class_e'(in_class_i), rd: in_rd_i, rs1: in_rs1_i,
                  rs2: in_rs2_i, f3: in_funct3_i, f7: in_funct7_i, imm: WORD_W'(in_imm_i)};

  instr_word_encoder u_enc (
    .desc (desc),
    .word (enc_word),
    .err  (enc_err)
  );

  assign handshake = we_q && mem_ready_i;
  assign at_max    = &addr_q[ADDR_W-1:2];

  // Next-state, datapath and handshake logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    code_d  = code_q;
    csum_d  = csum_q;
    ready_c = 1'b0;

    if (handshake) begin
      addr_d  = addr_q + ADDR_W'(4);
      count_d = count_q + ADDR_W'(1);
      we_d    = 1'b0;
      csum_d  = csum_q ^ wdata_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i & ~ADDR_W'(3);
          count_d = '0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          csum_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A pending write at the top word must not be followed by another
        ready_c = (!we_q || mem_ready_i) && !(we_q && at_max);
        if (in_valid_i && ready_c) begin
          we_d    = 1'b1;
          wdata_d = XLEN'(enc_word);
          if (enc_err != ERR_NONE) begin
            err_d = 1'b1;
            if (code_q == ERR_NONE) code_d = enc_err;
          end
          if (in_last_i) state_d = ST_DRAIN;
        end else if (handshake && at_max) begin
          err_d = 1'b1;
          if (code_q == ERR_NONE) code_d = ERR_ADDR;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!we_q || mem_ready_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      csum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      code_q  <= code_d;
      csum_q  <= csum_d;
      busy_q  <= state_d != ST_IDLE;
      done_q  <= state_d == ST_DONE;
    end
  end

  assign in_ready_o   = ready_c;
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;
  assign word_count_o = count_q;

`ifdef ENCODER_CHECKSUM_EN
  assign checksum_o = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule
